uart_tx_arbiter: RTL and testbench

//   Shares one uart_tx serializer between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one uart_tx serializer between NUM_REQ requesters.
// Optional feature macro UART_ARB_HDR_EN: each granted packet is preceded by header byte HDR_BASE | index.
module uart_tx_arbiter #(
  parameter int                       NUM_REQ       = 4,
  parameter int                       NUM_DATA_BITS = 8,
  parameter int                       MAX_PKT_LEN   = 16,
  parameter logic [NUM_DATA_BITS-1:0] HDR_BASE      = 8'hA0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*NUM_DATA_BITS-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]               i_req_last,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic [NUM_DATA_BITS-1:0]         o_tx_byte,
  output logic                             o_tx_start,
  input  logic                             i_tx_busy,
  output logic                             o_pkt_trunc
);
  localparam int               IDX_W   = $clog2(NUM_REQ);
  localparam int               CNT_W   = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef UART_ARB_HDR_EN
    S_HDR,
`endif
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                   state, state_n;
  logic [IDX_W-1:0]         gidx, gidx_n, ptr, ptr_n, winner;
  logic [CNT_W-1:0]         count, count_n;
  logic                     last_q, last_n;
  logic [NUM_REQ-1:0]       grant_n, rot;
  logic [NUM_DATA_BITS-1:0] byte_n, sel_data;
  logic                     start_n, trunc_n, sel_valid, sel_last;
  int                       off, tmp;
`ifdef UART_ARB_HDR_EN
  logic                     hdr_q, hdr_n;
`endif

  // Rotate so bit 0 is the requester just after the last winner; lowest set bit wins.
  always_comb begin
    rot = NUM_REQ'({i_req_valid, i_req_valid} >> (ptr + 1'b1));
    off = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    tmp = int'(ptr) + 1 + off;
    if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
    winner = IDX_W'(tmp);
  end

  assign sel_data    = i_req_data[int'(gidx) * NUM_DATA_BITS +: NUM_DATA_BITS];
  assign sel_valid   = i_req_valid[gidx];
  assign sel_last    = i_req_last[gidx];
  assign o_req_ready = (state == S_SEND && !i_tx_busy) ? o_grant : '0;

  always_comb begin
    state_n = state;
    grant_n = o_grant;
    gidx_n  = gidx;
    ptr_n   = ptr;
    count_n = count;
    last_n  = last_q;
    byte_n  = o_tx_byte;
    start_n = 1'b0;
    trunc_n = 1'b0;
`ifdef UART_ARB_HDR_EN
    hdr_n   = hdr_q;
`endif
    case (state)
      S_IDLE: begin
        if (|i_req_valid) begin
          gidx_n  = winner;
          ptr_n   = winner;
          grant_n = NUM_REQ'(1) << winner;
`ifdef UART_ARB_HDR_EN
          state_n = S_HDR;
`else
          state_n = S_SEND;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      S_HDR: begin
        if (!i_tx_busy) begin
          byte_n  = HDR_BASE | NUM_DATA_BITS'(gidx);
          start_n = 1'b1;
          hdr_n   = 1'b1;
          state_n = S_WAIT_BUSY;
        end
      end
`endif
      S_SEND: begin
        if (sel_valid && !i_tx_busy) begin
          byte_n  = sel_data;
          start_n = 1'b1;
          last_n  = sel_last;
          if (count != CNT_MAX) count_n = count + 1'b1;
          state_n = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
`ifdef UART_ARB_HDR_EN
          if (hdr_q) begin
            hdr_n   = 1'b0;
            state_n = S_SEND;
          end else
`endif
          if (last_q || count == CNT_MAX) begin
            // Release; a cut without last is flagged so the sink can resync.
            grant_n = '0;
            count_n = '0;
            trunc_n = !last_q;
            state_n = S_IDLE;
          end else begin
            state_n = S_SEND;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      o_grant     <= '0;
      gidx        <= '0;
      ptr         <= IDX_W'(NUM_REQ - 1);
      count       <= '0;
      last_q      <= 1'b0;
      o_tx_byte   <= '0;
      o_tx_start  <= 1'b0;
      o_pkt_trunc <= 1'b0;
`ifdef UART_ARB_HDR_EN
      hdr_q       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      o_grant     <= grant_n;
      gidx        <= gidx_n;
      ptr         <= ptr_n;
      count       <= count_n;
      last_q      <= last_n;
      o_tx_byte   <= byte_n;
      o_tx_start  <= start_n;
      o_pkt_trunc <= trunc_n;
`ifdef UART_ARB_HDR_EN
      hdr_q       <= hdr_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte streams per requester, a uart_tx busy model,
// and a packet-level round-robin reference model predicting start bytes, owners and truncations.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int         N    = 4;
  localparam int         W    = 8;
  localparam int         MAXL = 16;
  localparam logic [7:0] HDR  = 8'hA0;

  logic         clk = 1'b0;
  logic         rst, busy, tx_start, trunc;
  logic [N-1:0] valid, last, ready, grant;
  logic [N*W-1:0] data;
  logic [W-1:0] tx_byte;

  uart_tx_arbiter #(
    .NUM_REQ(N), .NUM_DATA_BITS(W), .MAX_PKT_LEN(MAXL), .HDR_BASE(HDR)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data),
    .i_req_last(last), .o_req_ready(ready), .o_grant(grant), .o_tx_byte(tx_byte),
    .o_tx_start(tx_start), .i_tx_busy(busy), .o_pkt_trunc(trunc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int busy_len = 4;
  int bcnt;

  // uart_tx stand-in: busy for busy_len cycles starting the cycle after a start pulse
  initial begin
    logic st;
    busy = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      st = tx_start;
      @(posedge clk);
      #1;
      if (bcnt > 0) bcnt--;
      if (st) bcnt = busy_len;
      busy = (bcnt > 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // stimulus streams (sq) and the model's copy (mq): {last, byte}
  logic [8:0] sq[N][$];
  logic [8:0] mq[N][$];
  int         m_ptr;
  int         m_owner;

  int         exp_idx[$];
  logic [7:0] exp_byte[$];
  int         exp_trunc[$];
  logic [N-1:0] obs_grant[$];
  logic [7:0] obs_byte[$];
  int         obs_trunc[$];

  task automatic push_byte(input int k, input logic [7:0] b, input logic l);
    sq[k].push_back({l, b});
    mq[k].push_back({l, b});
  endtask

  task automatic drive_fronts();
    for (int k = 0; k < N; k++) begin
      if (sq[k].size() > 0) begin
        valid[k]       = 1'b1;
        data[k*W +: W] = sq[k][0][7:0];
        last[k]        = sq[k][0][8];
      end else begin
        valid[k]       = 1'b0;
        data[k*W +: W] = 8'($urandom);
        last[k]        = 1'($urandom);
      end
    end
  endtask

  // Reference: whole packets in round-robin order, cut at MAXL bytes without last.
  task automatic model_run();
    int w, n;
    logic [8:0] e;
    bit done, stuck;
    exp_idx.delete(); exp_byte.delete(); exp_trunc.delete();
    m_owner = -1;
    stuck = 0;
    while (!stuck) begin
      w = -1;
      for (int i = N; i >= 1; i--) begin
        if (mq[(m_ptr + i) % N].size() > 0) w = (m_ptr + i) % N;
      end
      if (w < 0) break;
      m_ptr = w;
`ifdef UART_ARB_HDR_EN
      exp_idx.push_back(w);
      exp_byte.push_back(HDR | 8'(w));
`endif
      n = 0;
      done = 0;
      while (!done) begin
        if (mq[w].size() == 0) begin
          stuck = 1; m_owner = w; done = 1;
        end else begin
          e = mq[w].pop_front();
          exp_idx.push_back(w);
          exp_byte.push_back(e[7:0]);
          n++;
          if (e[8]) done = 1;
          else if (n == MAXL) begin
            done = 1;
            exp_trunc.push_back(exp_byte.size());
          end
        end
      end
    end
  endtask

  task automatic run_traffic(input string name);
    int budget, cyc, settle, exp_n;
    logic [N-1:0] hs, exp_g;
    bit empty;
    obs_grant.delete(); obs_byte.delete(); obs_trunc.delete();
    model_run();
    exp_n  = exp_byte.size();
    budget = 300 + exp_n * (busy_len + 8);
    cyc = 0;
    settle = 0;
    drive_fronts();
    while (cyc < budget && settle < 6) begin
      @(negedge clk);
      hs = valid & ready;
      total++;
      if (((ready & ~grant) !== '0) || !$onehot0(grant)) begin
        bad++;
        $display("FAIL %s ready_in_grant: ready=%b grant=%b want ready within one-hot grant", name, ready, grant);
      end
      if (tx_start === 1'b1) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL %s start_while_busy: busy=%b want 0", name, busy);
        end
        obs_grant.push_back(grant);
        obs_byte.push_back(tx_byte);
      end
      if (trunc === 1'b1) obs_trunc.push_back(obs_byte.size());
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (hs[k]) void'(sq[k].pop_front());
      drive_fronts();
      cyc++;
      empty = 1;
      for (int k = 0; k < N; k++) if (sq[k].size() > 0) empty = 0;
      if (obs_byte.size() >= exp_n && empty && !busy) settle++;
      else settle = 0;
    end
    total++;
    if (settle < 6) begin
      bad++;
      $display("FAIL %s timeout: got %0d starts after %0d cycles want %0d", name, obs_byte.size(), cyc, exp_n);
    end
    total++;
    if (obs_byte.size() != exp_n) begin
      bad++;
      $display("FAIL %s start_count: got %0d want %0d", name, obs_byte.size(), exp_n);
    end
    for (int i = 0; i < exp_n && i < obs_byte.size(); i++) begin
      exp_g = '0;
      exp_g[exp_idx[i]] = 1'b1;
      total++;
      if (obs_byte[i] !== exp_byte[i] || obs_grant[i] !== exp_g) begin
        bad++;
        $display("FAIL %s start[%0d]: got byte %h grant %b want byte %h grant %b",
                 name, i, obs_byte[i], obs_grant[i], exp_byte[i], exp_g);
      end
    end
    total++;
    if (obs_trunc.size() != exp_trunc.size()) begin
      bad++;
      $display("FAIL %s trunc_count: got %0d want %0d", name, obs_trunc.size(), exp_trunc.size());
    end
    for (int i = 0; i < exp_trunc.size() && i < obs_trunc.size(); i++) begin
      total++;
      if (obs_trunc[i] != exp_trunc[i]) begin
        bad++;
        $display("FAIL %s trunc_pos[%0d]: got after %0d starts want %0d", name, i, obs_trunc[i], exp_trunc[i]);
      end
    end
    exp_g = '0;
    if (m_owner >= 0) exp_g[m_owner] = 1'b1;
    total++;
    if (grant !== exp_g) begin
      bad++;
      $display("FAIL %s final_grant: got %b want %b", name, grant, exp_g);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = '0;
    last = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    m_ptr = N - 1;
    for (int k = 0; k < N; k++) begin sq[k].delete(); mq[k].delete(); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = '1;
    last = '1;
    data = {$urandom, $urandom};
    repeat (4) begin
      @(negedge clk);
      total++;
      if (grant !== '0 || tx_start !== 1'b0 || trunc !== 1'b0 || tx_byte !== '0 || ready !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got grant=%b start=%b trunc=%b byte=%h ready=%b want all zero",
                 grant, tx_start, trunc, tx_byte, ready);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid = '0;
    m_ptr = N - 1;
  endtask

  task automatic test_single();
    busy_len = 20;
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b0);
    push_byte(1, 8'h33, 1'b1);
    run_traffic("single");
  endtask

  task automatic test_rr();
    do_reset();
    busy_len = 3;
    push_byte(0, 8'h01, 1'b0); push_byte(0, 8'h02, 1'b1);
    push_byte(0, 8'h03, 1'b0); push_byte(0, 8'h04, 1'b1);
    push_byte(2, 8'h21, 1'b0); push_byte(2, 8'h22, 1'b1);
    push_byte(2, 8'h23, 1'b0); push_byte(2, 8'h24, 1'b1);
    run_traffic("rr_pair");
    for (int k = 0; k < N; k++) begin
      push_byte(k, 8'(8'h40 + k), 1'b0);
      push_byte(k, 8'(8'h50 + k), 1'b1);
    end
    run_traffic("rr_all");
  endtask

  task automatic test_trunc();
    do_reset();
    busy_len = 2;
    for (int i = 0; i < 20; i++) push_byte(3, 8'($urandom), 1'b0);
    run_traffic("trunc");
    total++;
    if (obs_trunc.size() != 1 || obs_byte.size() != 20) begin
      bad++;
      $display("FAIL trunc_shape: got %0d pulses %0d starts want 1 pulse", obs_trunc.size(), obs_byte.size());
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit seen;
    do_reset();
    busy_len = 20;
    valid = 4'b0010;
    data[1*W +: W] = 8'h11;
    last = '0;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1;
      n++;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_reset_start: got no start in %0d cycles want one", n);
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (grant !== '0 || tx_start !== 1'b0 || trunc !== 1'b0 || tx_byte !== '0 || ready !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got grant=%b start=%b trunc=%b byte=%h ready=%b want all zero",
               grant, tx_start, trunc, tx_byte, ready);
    end
    m_ptr = N - 1;
    for (int k = 0; k < N; k++) begin sq[k].delete(); mq[k].delete(); end
    push_byte(2, 8'hC4, 1'b1);
    run_traffic("after_reset");
  endtask

`ifdef UART_ARB_HDR_EN
  task automatic test_header();
    do_reset();
    busy_len = 3;
    push_byte(2, 8'h5A, 1'b1);
    run_traffic("header");
    total++;
    if (obs_byte.size() != 2 || obs_byte[0] !== 8'hA2 || obs_byte[1] !== 8'h5A) begin
      bad++;
      $display("FAIL header_bytes: got %0d starts want A2 then 5A", obs_byte.size());
    end
  endtask
`endif

  task automatic test_random();
    int len;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      busy_len = $urandom_range(1, 6);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          len = $urandom_range(1, 36);
          for (int i = 0; i < len; i++)
            push_byte(k, 8'($urandom), ($urandom_range(0, 5) == 0) || (i == len - 1));
        end
      end
      run_traffic("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    valid = '0;
    last = '0;
    data = '0;
    m_ptr = N - 1;
    m_owner = -1;
    test_reset();
    test_single();
    test_rr();
    test_trunc();
    test_mid_reset();
`ifdef UART_ARB_HDR_EN
    test_header();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
